// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access target: FSM state encoding and default device address.
package i2c_pkg;

  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h21;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_SUB_ADDR,
    ST_SUB_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_MACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the iCLK domain and flags SCL edges and START/STOP conditions.
module i2c_bus_sync (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SDA moving while SCL is high is a bus condition, never data.
  assign start_o    = scl_s & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing an 8-bit register file: sub-address write, auto-incrementing burst write and read.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       byte_done_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       reg_we_q;
  logic       busy_q;

  i2c_bus_sync u_sync (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .scl_i      (I2C_SCLK),
    .sda_i      (I2C_SDAT),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  // Open drain: the flop reset releases the line without waiting for a clock.
  assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign REG_WE    = reg_we_q;
  assign BUSY      = busy_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      if (reg_we_q) reg_addr_q <= reg_addr_q + 8'd1;

      if (start_det) begin
        state_q     <= ST_DEV_ADDR;
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
        sda_oe_q    <= 1'b0;
      end else if (stop_det) begin
        state_q     <= ST_IDLE;
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          // Bytes complete on the 8th rise; the resulting action waits for the next fall.
          ST_DEV_ADDR, ST_SUB_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
            end else if (scl_fall && byte_done_q) begin
              byte_done_q <= 1'b0;
              case (state_q)
                ST_DEV_ADDR: begin
                  if (shift_q[7:1] == SLAVE_ADDR) begin
                    state_q  <= ST_DEV_ACK;
                    sda_oe_q <= 1'b1;
                    busy_q   <= 1'b1;
                    rw_q     <= shift_q[0];
                  end else begin
                    state_q <= ST_IGNORE;
                    busy_q  <= 1'b0;
                  end
                end
                ST_SUB_ADDR: begin
                  state_q    <= ST_SUB_ACK;
                  sda_oe_q   <= 1'b1;
                  reg_addr_q <= shift_q;
                end
                default: begin
                  state_q     <= ST_WR_ACK;
                  sda_oe_q    <= 1'b1;
                  reg_wdata_q <= shift_q;
                  reg_we_q    <= 1'b1;
                end
              endcase
            end
          end
          ST_DEV_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd0;
              if (rw_q) begin
                state_q  <= ST_RD_DATA;
                shift_q  <= REG_RDATA;
                sda_oe_q <= ~REG_RDATA[7];
              end else begin
                state_q  <= ST_SUB_ADDR;
                sda_oe_q <= 1'b0;
              end
            end
          end
          ST_SUB_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              state_q   <= ST_WR_DATA;
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
            end else if (scl_fall) begin
              if (byte_done_q) begin
                byte_done_q <= 1'b0;
                state_q     <= ST_RD_MACK;
                sda_oe_q    <= 1'b0;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          // Address advances on the ACK rise so REG_RDATA has settled by the reload fall.
          ST_RD_MACK: begin
            if (scl_rise) begin
              if (sda_s) state_q <= ST_IGNORE;
              else       reg_addr_q <= reg_addr_q + 8'd1;
            end else if (scl_fall) begin
              state_q   <= ST_RD_DATA;
              shift_q   <= REG_RDATA;
              sda_oe_q  <= ~REG_RDATA[7];
              bit_cnt_q <= 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h21, is the 7-bit device address; the write byte is 8'h42 and the read byte is 8'h43.
REQ-002 iCLK  input  1  system clock; the block samples everything on its rising edge.
REQ-003 iRST_N  input  1  reset, asynchronous, active-low.
REQ-004 I2C_SCLK  input  1  bus clock from the controller.
REQ-005 I2C_SDAT  inout  1  bus data, open-drain: the block drives either 0 or high-Z, never 1.
REQ-006 REG_ADDR  output  8  current register (sub) address.
REQ-007 REG_WDATA  output  8  last received write byte.
REQ-008 REG_WE  output  1  one-cycle write strobe.
REQ-009 REG_RDATA  input  8  read data for REG_ADDR; combinational from the register file.
REQ-010 BUSY  output  1  high from an address-matched START until STOP or abort.

Function
REQ-011 I2C_SCLK and I2C_SDAT shall each pass through a 2-flop synchronizer; edges are detected on the synchronized copies.
REQ-012 iCLK shall be at least 8x the SCL frequency.
REQ-013 START = synchronized SDA falls while synchronized SCL is high; STOP = synchronized SDA rises while synchronized SCL is high.
REQ-014 Data shall be sampled on the SCL rising edge, MSB first; the block shall change its SDA drive only on the SCL falling edge.
REQ-015 States: IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE.
REQ-016 START from any state, including a repeated START, shall go to DEV_ADDR and clear the 3-bit bit counter.
REQ-017 STOP from any state shall go to IDLE, release SDA and clear BUSY.
REQ-018 DEV_ADDR, after 8 bits:
  - upper 7 bits == SLAVE_ADDR -> DEV_ACK, driving SDA low for one SCL period and setting BUSY;
  - mismatch -> IGNORE, SDA released; exit only on START or STOP.
REQ-019 After DEV_ACK:
  - R/W bit = 0 -> SUB_ADDR;
  - R/W bit = 1 -> RD_DATA, loading the shift register from REG_RDATA on the SCL falling edge that ends the ACK.
REQ-020 SUB_ADDR, after 8 bits -> SUB_ACK (drive 0); REG_ADDR is updated on the falling edge that begins the ACK.
REQ-021 After SUB_ACK -> WR_DATA.
REQ-022 WR_DATA, after 8 bits:
  - REG_WDATA loaded and REG_WE high for exactly one iCLK cycle, starting the cycle after the falling edge that ends bit 8;
  - -> WR_ACK (drive 0), then back to WR_DATA;
  - REG_ADDR increments by 1 (mod 256, 8'hFF wraps to 8'h00) in the cycle after REG_WE.
REQ-023 RD_DATA drives a 0 bit as 0 and a 1 bit as Z; after 8 bits -> RD_MACK with SDA released.
REQ-024 RD_MACK, sampled on the SCL rising edge:
  - ACK (0) -> REG_ADDR increments, shift register reloads from REG_RDATA at the falling edge, -> RD_DATA;
  - NACK (1) -> IGNORE until STOP.
REQ-025 STOP arriving mid-byte shall discard the partial byte: no REG_WE and no REG_ADDR change.
REQ-026 When START or STOP coincides with an SCL edge in the same iCLK cycle, START/STOP takes priority.

Reset
REQ-027 Reset shall asynchronously force: state IDLE, SDA released (Z), REG_ADDR 8'h00, REG_WDATA 8'h00, REG_WE 0, BUSY 0, bit counter 0, synchronizer flops 1.
REQ-028 Reset asserted mid-transfer shall release SDA in the same instant, with no iCLK edge required.

Structure
REQ-029 The state encoding and the default SLAVE_ADDR shall live in a shared package, i2c_pkg.
REQ-030 One sub-module, i2c_bus_sync, shall hold the synchronizers, the SCL rise/fall detectors and the START/STOP detectors.

Verification
REQ-031 Write 42 12 80 with STOP -> three ACKs (SDA low at the ACK bits); REG_WE pulses once with REG_ADDR=12, REG_WDATA=80; afterwards REG_ADDR=13.
REQ-032 Write 42 0A, STOP, START, 43, REG_RDATA=76, controller NACK -> bus byte read is 76; BUSY falls at STOP.
REQ-033 Address 44 -> SDA never driven low for the whole transfer; no REG_WE.
REQ-034 Write 42 FF AA BB -> REG_WE at addresses FF then 00; final REG_ADDR=01.
REQ-035 STOP after 4 bits of a data byte -> no REG_WE; REG_ADDR unchanged; state IDLE.
REQ-036 iRST_N low during an ACK bit -> SDA reads Z immediately; all outputs at their reset values.
